// File: rtl/alu_result_tx.sv
// Serialises a 16-bit ALU result into MSB-first bytes for a UART transmitter.
// Define RESULT_CHECKSUM_EN to append a third byte holding high^low.
module alu_result_tx #(
  parameter int NB_RESULT = 16,
  parameter int NB_BYTE   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_result_valid,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_busy,
  output logic                 o_overrun
);

`ifdef RESULT_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [NB_RESULT-1:0] shadow_q, shadow_d;
  logic                 tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  function automatic logic [NB_BYTE-1:0] byte_sel(input logic [NB_RESULT-1:0] r,
                                                   input logic [1:0] idx);
    logic [NB_BYTE-1:0] b;
    case (idx)
      2'd0:    b = r[NB_RESULT-1 -: NB_BYTE];
      2'd1:    b = r[NB_BYTE-1:0];
`ifdef RESULT_CHECKSUM_EN
      2'd2:    b = r[NB_RESULT-1 -: NB_BYTE] ^ r[NB_BYTE-1:0];
`endif
      default: b = '0;
    endcase
    return b;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_result_valid) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (i_tx_done) state_d = (idx_q == LAST_IDX) ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // The start pulse and its byte are registered on the edge that enters START,
  // so o_tx_start is high for exactly the cycle the FSM spends in START.
  always_comb begin
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = (state_d != IDLE);
    overrun_d  = i_result_valid && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_result_valid) begin
          shadow_d   = i_result;
          idx_d      = '0;
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel(i_result, 2'd0);
        end
      end
      WAIT: begin
        if (i_tx_done && (idx_q != LAST_IDX)) begin
          idx_d      = idx_q + 2'd1;
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel(shadow_q, idx_q + 2'd1);
        end
      end
      default: ;
    endcase
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed self-checking bench for alu_result_tx; follows RESULT_CHECKSUM_EN
// for the expected frame length.
module tb_alu_result_tx;

`ifdef RESULT_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clk;
  logic        i_reset;
  logic        i_result_valid;
  logic [15:0] i_result;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] sent [$];
  int         ovr_cnt = 0;
  bit         clr_mon = 0;

  alu_result_tx #(.NB_RESULT(16), .NB_BYTE(8)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_result_valid (i_result_valid),
    .i_result       (i_result),
    .i_tx_done      (i_tx_done),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every transmitted byte and overrun pulse between edges
  always @(negedge clk) begin
    if (clr_mon) begin
      sent.delete();
      ovr_cnt = 0;
    end else begin
      if (o_tx_start) sent.push_back(o_tx_data);
      if (o_overrun) ovr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    clr_mon = 1;
    @(negedge clk);
    #1;
    clr_mon = 0;
  endtask

  task automatic run_frame(input logic [15:0] val, input int gap, input string tag);
    logic [7:0] exp [3];
    bit stable;
    exp[0] = val[15:8];
    exp[1] = val[7:0];
    exp[2] = val[15:8] ^ val[7:0];
    i_result = val;
    i_result_valid = 1;
    step();
    i_result_valid = 0;
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (o_tx_start !== 1'b1) begin
        errors++; $display("FAIL %s start%0d: got %b want 1", tag, b, o_tx_start);
      end
      checks++;
      if (o_tx_data !== exp[b]) begin
        errors++; $display("FAIL %s data%0d: got %h want %h", tag, b, o_tx_data, exp[b]);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++; $display("FAIL %s busy%0d: got %b want 1", tag, b, o_busy);
      end
      stable = 1;
      for (int k = 0; k < gap; k++) begin
        step();
        if (o_tx_start !== 1'b0 || o_tx_data !== exp[b] || o_busy !== 1'b1) stable = 0;
      end
      checks++;
      if (stable !== 1'b1) begin
        errors++; $display("FAIL %s hold%0d: got unstable outputs want stable %h", tag, b, exp[b]);
      end
      i_tx_done = 1;
      step();
      i_tx_done = 0;
    end
    checks++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
      errors++; $display("FAIL %s end: got busy=%b start=%b want 0 0", tag, o_busy, o_tx_start);
    end
  endtask

  task automatic test_reset();
    i_reset = 0; i_result_valid = 0; i_result = '0; i_tx_done = 0;
    repeat (3) step();
    checks++;
    if (o_tx_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", o_tx_start); end
    checks++;
    if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", o_tx_data); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", o_overrun); end
  endtask

  // Valid is raised in the same cycle reset is released
  task automatic test_basic();
    clear_monitor();
    @(posedge clk); #1;
    i_reset = 1;
    run_frame(16'h1234, 20, "basic");
    step();
    checks++;
    if (sent.size() !== NB) begin errors++; $display("FAIL basic_count: got %0d want %0d", sent.size(), NB); end
    else begin
      checks++;
      if (sent[0] !== 8'h12 || sent[1] !== 8'h34) begin
        errors++; $display("FAIL basic_bytes: got %h %h want 12 34", sent[0], sent[1]);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (sent[2] !== 8'h26) begin errors++; $display("FAIL basic_csum: got %h want 26", sent[2]); end
`endif
    end
    checks++;
    if (ovr_cnt !== 0) begin errors++; $display("FAIL basic_overrun: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_negative();
    clear_monitor();
    run_frame(16'hFED4, 3, "neg");
    step();
    checks++;
    if (sent.size() !== NB) begin errors++; $display("FAIL neg_count: got %0d want %0d", sent.size(), NB); end
    else begin
      checks++;
      if (sent[0] !== 8'hFE || sent[1] !== 8'hD4) begin
        errors++; $display("FAIL neg_bytes: got %h %h want fe d4", sent[0], sent[1]);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (sent[2] !== 8'h2A) begin errors++; $display("FAIL neg_csum: got %h want 2a", sent[2]); end
`endif
    end
  endtask

  task automatic test_overrun();
    clear_monitor();
    i_result = 16'h1234; i_result_valid = 1;
    step();
    i_result_valid = 0;
    repeat (3) step();
    i_result = 16'h5555; i_result_valid = 1;
    step();
    i_result_valid = 0;
    checks++;
    if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", o_overrun); end
    step();
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_single: got %b want 0", o_overrun); end
    for (int b = 1; b < NB; b++) begin
      i_tx_done = 1; step(); i_tx_done = 0;
      checks++;
      if (o_tx_start !== 1'b1) begin errors++; $display("FAIL ovr_start%0d: got %b want 1", b, o_tx_start); end
      repeat (2) step();
    end
    // Final done coincides with a new valid: still dropped
    i_tx_done = 1; i_result_valid = 1;
    step();
    i_tx_done = 0; i_result_valid = 0;
    checks++;
    if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL ovr_last: got ovr=%b busy=%b want 1 0", o_overrun, o_busy);
    end
    step();
    checks++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_drop: got start=%b busy=%b ovr=%b want 0 0 0", o_tx_start, o_busy, o_overrun);
    end
    step();
    checks++;
    if (sent.size() !== NB) begin errors++; $display("FAIL ovr_count: got %0d want %0d", sent.size(), NB); end
    else begin
      checks++;
      if (sent[0] !== 8'h12 || sent[1] !== 8'h34) begin
        errors++; $display("FAIL ovr_bytes: got %h %h want 12 34", sent[0], sent[1]);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (sent[2] !== 8'h26) begin errors++; $display("FAIL ovr_csum: got %h want 26", sent[2]); end
`endif
    end
    checks++;
    if (ovr_cnt !== 2) begin errors++; $display("FAIL ovr_total: got %0d want 2", ovr_cnt); end
  endtask

  task automatic test_done_ignored();
    bit quiet;
    clear_monitor();
    quiet = 1;
    for (int k = 0; k < 3; k++) begin
      i_tx_done = 1; step(); i_tx_done = 0; step();
      if (o_tx_start !== 1'b0 || o_busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL idle_done: got activity want none"); end
    i_result = 16'h8001; i_result_valid = 1;
    step();
    i_result_valid = 0;
    i_tx_done = 1;
    step();
    i_tx_done = 0;
    quiet = 1;
    for (int k = 0; k < 3; k++) begin
      if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_tx_data !== 8'h80) quiet = 0;
      step();
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL start_done: got advance want hold on 80"); end
    i_tx_done = 1; step(); i_tx_done = 0;
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h01) begin
      errors++; $display("FAIL start_done_b1: got %b %h want 1 01", o_tx_start, o_tx_data);
    end
    for (int b = 1; b < NB; b++) begin
      step();
      i_tx_done = 1; step(); i_tx_done = 0;
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL start_done_end: got %b want 0", o_busy); end
    step();
    checks++;
    if (sent.size() !== NB) begin errors++; $display("FAIL start_done_count: got %0d want %0d", sent.size(), NB); end
  endtask

  task automatic test_reset_midframe();
    bit quiet;
    clear_monitor();
    i_result = 16'h00FF; i_result_valid = 1;
    step();
    i_result_valid = 0;
    repeat (3) step();
    #2 i_reset = 0;
    #1;
    checks++;
    if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      errors++; $display("FAIL async_rst: got %b %h %b %b want 0 00 0 0", o_tx_start, o_tx_data, o_busy, o_overrun);
    end
    @(posedge clk); #1;
    i_reset = 1;
    i_tx_done = 1; step(); i_tx_done = 0;
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      if (o_tx_start !== 1'b0 || o_busy !== 1'b0) quiet = 0;
      step();
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL post_rst_done: got activity want none"); end
    clear_monitor();
    run_frame(16'hABCD, 4, "after_rst");
    step();
    checks++;
    if (sent.size() !== NB) begin errors++; $display("FAIL after_rst_count: got %0d want %0d", sent.size(), NB); end
    else begin
      checks++;
      if (sent[0] !== 8'hAB || sent[1] !== 8'hCD) begin
        errors++; $display("FAIL after_rst_bytes: got %h %h want ab cd", sent[0], sent[1]);
      end
`ifdef RESULT_CHECKSUM_EN
      checks++;
      if (sent[2] !== 8'h66) begin errors++; $display("FAIL after_rst_csum: got %h want 66", sent[2]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overrun();
    test_done_ignored();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
